// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// The optional early-termination feature is selected with MDU_EARLY_TERM_EN.
package mdu_pkg;

   localparam int MDU_WIDTH = 32;

   localparam logic [1:0] MDU_MULT  = 2'd0;
   localparam logic [1:0] MDU_MULTU = 2'd1;
   localparam logic [1:0] MDU_DIV   = 2'd2;
   localparam logic [1:0] MDU_DIVU  = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_e;

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module mdu_div_step
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             dvd_bit_i,
   input  logic [WIDTH-1:0] dvs_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_o
);

   logic [WIDTH:0] shifted;

   // The restored remainder is always below the divisor, so modular WIDTH-bit subtraction is exact.
   always_comb begin
      shifted = {rem_i, dvd_bit_i};
      q_o     = (shifted >= {1'b0, dvs_i});
      rem_o   = q_o ? (shifted[WIDTH-1:0] - dvs_i) : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/mdu_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit feeding the HI/LO registers, with MTHI/MTLO write-through.
// Define MDU_EARLY_TERM_EN to let multiplies finish once the remaining multiplier bits are zero.
module mdu_seq
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_wr,
   input  logic             lo_wr,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [1:0]           op_q, op_d;
   logic                 sa_q, sa_d;
   logic                 sb_q, sb_d;
   logic                 dz_q, dz_d;
   logic                 done_q, done_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;

   logic [WIDTH-1:0]     rem_nxt;
   logic                 q_bit;
   logic [WIDTH:0]       sum;
   logic [2*WIDTH-1:0]   prod;
   logic                 is_signed;
   logic                 is_div;
   logic                 last;

   function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
      return n ? (~v + WIDTH'(1)) : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_if2(input logic [2*WIDTH-1:0] v, input logic n);
      return n ? (~v + (2*WIDTH)'(1)) : v;
   endfunction

   mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
      .dvd_bit_i (acc_q[WIDTH-1]),
      .dvs_i     (mcand_q),
      .rem_o     (rem_nxt),
      .q_o       (q_bit)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      op_d      = op_q;
      sa_d      = sa_q;
      sb_d      = sb_q;
      dz_d      = dz_q;
      done_d    = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;
      is_signed = (op == MDU_MULT) || (op == MDU_DIV);
      is_div    = op[1];
      last      = 1'b0;
      prod      = acc_q;
      sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (mplier_q[0] ? mcand_q : '0)};

      case (state_q)
         IDLE: begin
            if (hi_wr) hi_d = wdata;
            if (lo_wr) lo_d = wdata;
            if (start) begin
               op_d  = op;
               cnt_d = '0;
               sa_d  = is_signed & a[WIDTH-1];
               sb_d  = is_signed & b[WIDTH-1];
               dz_d  = is_div && (b == '0);
               if (dz_d) begin
                  // Raw dividend parked in the low half so FIX can return it untouched.
                  acc_d    = {{WIDTH{1'b0}}, a};
                  mcand_d  = '0;
                  mplier_d = '0;
                  state_d  = FIX;
               end else if (is_div) begin
                  acc_d    = {{WIDTH{1'b0}}, neg_if(a, sa_d)};
                  mcand_d  = neg_if(b, sb_d);
                  mplier_d = '0;
                  state_d  = CALC;
               end else begin
                  acc_d    = '0;
                  mcand_d  = neg_if(a, sa_d);
                  mplier_d = neg_if(b, sb_d);
                  state_d  = CALC;
               end
            end
         end
         CALC: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (op_q[1]) begin
               acc_d = {rem_nxt, acc_q[WIDTH-2:0], q_bit};
            end else begin
               acc_d    = {sum, acc_q[WIDTH-1:1]};
               mplier_d = mplier_q >> 1;
            end
            last = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef MDU_EARLY_TERM_EN
            if (!op_q[1] && (mplier_q[WIDTH-1:1] == '0)) last = 1'b1;
`endif
            if (last) state_d = FIX;
         end
         FIX: begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (dz_q) begin
               hi_d = acc_q[WIDTH-1:0];
               lo_d = '1;
            end else if (op_q[1]) begin
               lo_d = neg_if(acc_q[WIDTH-1:0], sa_q ^ sb_q);
               hi_d = neg_if(acc_q[2*WIDTH-1:WIDTH], sa_q);
            end else begin
`ifdef MDU_EARLY_TERM_EN
               // Partial product still sits WIDTH-cnt positions high after an early exit.
               prod = acc_q >> (WIDTH - int'(cnt_q));
`else
               prod = acc_q;
`endif
               prod = neg_if2(prod, sa_q ^ sb_q);
               hi_d = prod[2*WIDTH-1:WIDTH];
               lo_d = prod[WIDTH-1:0];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         op_q     <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         dz_q     <= 1'b0;
         done_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         op_q     <= op_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         dz_q     <= dz_d;
         done_q   <= done_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign div_zero = dz_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq; latency expectations follow MDU_EARLY_TERM_EN.
module tb_mdu_seq;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'd0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        hi_wr = 1'b0;
   logic        lo_wr = 1'b0;
   logic [31:0] wdata = '0;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int tests = 0;
   int fails = 0;

   mdu_seq #(.WIDTH(32), .CNT_W(6)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .hi_wr    (hi_wr),
      .lo_wr    (lo_wr),
      .wdata    (wdata),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Edges from the start edge to the edge after which done is visible.
   function automatic int mult_lat(input logic [31:0] mag_b);
`ifdef MDU_EARLY_TERM_EN
      int k = 0;
      for (int i = 0; i < 32; i++) if (mag_b[i]) k = i;
      return k + 2;
`else
      return 33 + 0 * int'(mag_b[0]);
`endif
   endfunction

   // Called #1 after a rising edge; returns #1 after the start edge.
   task automatic issue(input logic [1:0] o, input logic [31:0] ia, input logic [31:0] ib);
      op = o; a = ia; b = ib; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!done && n < 100);
   endtask

   task automatic run(input string tag, input logic [1:0] o, input logic [31:0] ia,
                      input logic [31:0] ib, input int lat, input logic [31:0] ehi,
                      input logic [31:0] elo);
      int n;
      issue(o, ia, ib);
      wait_done(n);
      check({tag, "_lat"}, 32'(n), 32'(lat));
      check({tag, "_hi"}, hi, ehi);
      check({tag, "_lo"}, lo, elo);
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int n;
      int n0;
      int dones;

      #12;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_dz", 32'(div_zero), 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;

      run("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001);
      run("mult_neg", MDU_MULT, 32'hFFFF_FFFD, 32'd7, mult_lat(32'd7), 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run("divu", MDU_DIVU, 32'd7, 32'd2, 33, 32'd1, 32'd3);
      run("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);

      issue(MDU_DIVU, 32'h1234, 32'd0);
      wait_done(n);
      check("dz_lat", 32'(n), 32'd1);
      check("dz_lo", lo, 32'hFFFF_FFFF);
      check("dz_hi", hi, 32'h0000_1234);
      check("dz_flag", 32'(div_zero), 32'd1);
      issue(MDU_MULTU, 32'd6, 32'd7);
      check("dz_clear", 32'(div_zero), 32'd0);
      wait_done(n);
      check("m67_lat", 32'(n), 32'(mult_lat(32'd7)));
      check("m67_lo", lo, 32'd42);
      check("m67_hi", hi, 32'd0);

      issue(MDU_MULTU, 32'd5, 32'h8000_0000);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
      end
      op = MDU_DIVU; a = 32'd100; b = 32'd3; start = 1'b1;
      hi_wr = 1'b1; wdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      start = 1'b0; hi_wr = 1'b0;
      n0 = 9;
      check("busy_wr_hi", hi, 32'd0);
      check("busy_wr_lo", lo, 32'd42);
      wait_done(n);
      check("ign_lat", 32'(n0 + n), 32'd33);
      check("ign_hi", hi, 32'd2);
      check("ign_lo", lo, 32'h8000_0000);
      @(posedge clk); #1;
      check("ign_busy", 32'(busy), 32'd0);
      check("ign_done", 32'(done), 32'd0);

      hi_wr = 1'b1; wdata = 32'hA5A5_A5A5;
      @(posedge clk); #1;
      hi_wr = 1'b0;
      check("mthi_hi", hi, 32'hA5A5_A5A5);
      check("mthi_lo", lo, 32'h8000_0000);
      hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'h0BAD_F00D;
      @(posedge clk); #1;
      hi_wr = 1'b0; lo_wr = 1'b0;
      check("both_hi", hi, 32'h0BAD_F00D);
      check("both_lo", lo, 32'h0BAD_F00D);

      hi_wr = 1'b1; wdata = 32'h1111_1111;
      issue(MDU_MULTU, 32'd2, 32'd3);
      hi_wr = 1'b0;
      check("st_mthi_hi", hi, 32'h1111_1111);
      check("st_mthi_busy", 32'(busy), 32'd1);
      wait_done(n);
      check("st_mthi_lat", 32'(n), 32'(mult_lat(32'd3)));
      check("st_mthi_reshi", hi, 32'd0);
      check("st_mthi_reslo", lo, 32'd6);

      issue(MDU_DIV, 32'd100, 32'd7);
      for (int i = 0; i < 14; i++) begin
         @(posedge clk); #1;
      end
      reset_n = 1'b0;
      #1;
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_hi", hi, 32'd0);
      check("mrst_lo", lo, 32'd0);
      check("mrst_done", 32'(done), 32'd0);
      #2;
      reset_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      check("mrst_nodone", 32'(dones), 32'd0);
      run("post_rst", MDU_MULTU, 32'd6, 32'd7, mult_lat(32'd7), 32'd0, 32'd42);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
